// File: rtl/shift_serializer_pkg.sv
// shift_serializer_pkg: shared FSM state encoding and direction constants for the serializer.
package shift_serializer_pkg;
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;
endpackage

// File: rtl/shift_hold_buffer.sv
// shift_hold_buffer: one-entry word+direction register with a full flag.
module shift_hold_buffer
  import shift_serializer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic             rd,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_dir,
  output logic             full,
  output logic [WIDTH-1:0] q_data,
  output logic             q_dir
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full   <= 1'b0;
      q_data <= '0;
      q_dir  <= DIR_MSB_FIRST;
    end else begin
      full <= wr | (full & ~rd);
      if (wr) begin
        q_data <= wr_data;
        q_dir  <= wr_dir;
      end
    end
  end
endmodule

// File: rtl/shift_serializer.sv
// shift_serializer: parallel-to-serial shifter with a one-word hold buffer for gapless streaming.
module shift_serializer
  import shift_serializer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             direction,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_first,
  output logic             ser_last,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  state_t           state;
  logic [WIDTH-1:0] sh;
  logic             dir_q;
  logic [CW-1:0]    cnt;
  logic             hold_full, hold_dir;
  logic [WIDTH-1:0] hold_data;
  logic             accept, last_edge, reload, hold_rd, hold_wr;
  assign accept    = in_valid && in_ready;
  assign last_edge = (state == SHIFT) && enable && (cnt == CW'(WIDTH - 1));
  // A new word may enter the shifter only when it is idle or finishing its last bit.
  assign reload    = (state == IDLE) || last_edge;
  assign hold_rd   = hold_full && reload;
  assign hold_wr   = accept && !reload;
  shift_hold_buffer #(.WIDTH(WIDTH)) u_hold (
    .clk     (clk),
    .reset   (reset),
    .wr      (hold_wr),
    .rd      (hold_rd),
    .wr_data (in_data),
    .wr_dir  (direction),
    .full    (hold_full),
    .q_data  (hold_data),
    .q_dir   (hold_dir)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      sh    <= '0;
      dir_q <= DIR_MSB_FIRST;
      cnt   <= '0;
    end else if (hold_rd) begin
      state <= SHIFT;
      sh    <= hold_data;
      dir_q <= hold_dir;
      cnt   <= '0;
    end else if (accept && reload) begin
      state <= SHIFT;
      sh    <= in_data;
      dir_q <= direction;
      cnt   <= '0;
    end else if (state == SHIFT && enable) begin
      sh <= (dir_q == DIR_LSB_FIRST) ? {1'b0, sh[WIDTH-1:1]} : {sh[WIDTH-2:0], 1'b0};
      if (last_edge) state <= IDLE;
      else cnt <= cnt + CW'(1);
    end
  end
  assign ser_valid = (state == SHIFT) && enable;
  assign ser_out   = (dir_q == DIR_LSB_FIRST) ? sh[0] : sh[WIDTH-1];
  assign ser_first = ser_valid && (cnt == '0);
  assign ser_last  = ser_valid && (cnt == CW'(WIDTH - 1));
  assign in_ready  = !hold_full;
  assign busy      = (state == SHIFT) || hold_full;
endmodule

// File: tb/tb_shift_serializer.sv
// tb_shift_serializer: directed vectors, corner sequences and a queue-based random reference model.
module tb_shift_serializer;
  localparam int W = 8;
  logic clk = 1'b0, reset = 1'b0, enable = 1'b1, direction = 1'b0, in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic in_ready, ser_out, ser_valid, ser_first, ser_last, busy;
  int checks = 0, passes = 0;
  always #5 clk = ~clk;
  shift_serializer #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .direction (direction),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .ser_out   (ser_out),
    .ser_valid (ser_valid),
    .ser_first (ser_first),
    .ser_last  (ser_last),
    .busy      (busy)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  // seq lists the expected serial bits in emission order, leftmost first.
  typedef struct {logic [W-1:0] data; logic dir; logic [W-1:0] seq;} vec_t;
  typedef struct {logic [W-1:0] data; logic dir;} word_t;
  vec_t vecs[6];
  task automatic send_check(input logic [W-1:0] d, input logic dr, input logic [W-1:0] seq);
    in_valid = 1'b1; in_data = d; direction = dr;
    step;
    in_valid = 1'b0;
    #1;
    for (int k = 0; k < W; k++) begin
      chk("vec_valid", ser_valid, 1);
      chk("vec_bit", ser_out, seq[W-1-k]);
      chk("vec_first", ser_first, k == 0);
      chk("vec_last", ser_last, k == W - 1);
      if (k == 3) direction = ~dr;
      step;
    end
    chk("vec_done", ser_valid, 0);
    chk("vec_idle_busy", busy, 0);
  endtask
  initial begin
    logic [15:0] bb;
    logic [W-1:0] c3;
    word_t hold_q[$];
    word_t cur;
    bit act;
    int idx;
    bit acc;
    vecs[0] = '{8'hA5, 1'b0, 8'hA5};
    vecs[1] = '{8'hA5, 1'b1, 8'hA5};
    vecs[2] = '{8'h01, 1'b1, 8'h80};
    vecs[3] = '{8'h80, 1'b0, 8'h80};
    vecs[4] = '{8'h80, 1'b1, 8'h01};
    vecs[5] = '{8'h3A, 1'b1, 8'h5C};
    in_valid = 1'b1; in_data = 8'hFF;
    step;
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", ser_valid, 0);
    chk("rst_out", ser_out, 0);
    chk("rst_first", ser_first, 0);
    chk("rst_last", ser_last, 0);
    chk("rst_busy", busy, 0);
    in_valid = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 6; i++) send_check(vecs[i].data, vecs[i].dir, vecs[i].seq);
    // back-to-back words with no gap
    bb = 16'hF00F;
    in_valid = 1'b1; in_data = 8'hF0; direction = 1'b0;
    step;
    in_data = 8'h0F;
    #1;
    for (int k = 0; k < 16; k++) begin
      chk("b2b_valid", ser_valid, 1);
      chk("b2b_bit", ser_out, bb[15-k]);
      if (k >= 1 && k <= 7) chk("b2b_ready_low", in_ready, 0);
      if (k == 0 || k == 8) chk("b2b_ready_high", in_ready, 1);
      step;
      if (k == 0) in_valid = 1'b0;
    end
    chk("b2b_done", ser_valid, 0);
    // stall for three cycles after bit 3
    c3 = 8'hC3;
    in_valid = 1'b1; in_data = c3; direction = 1'b0;
    step;
    in_valid = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("stall_pre_bit", ser_out, c3[W-1-k]);
      chk("stall_pre_valid", ser_valid, 1);
      step;
    end
    enable = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("stall_valid", ser_valid, 0);
      chk("stall_first", ser_first, 0);
      chk("stall_last", ser_last, 0);
      chk("stall_busy", busy, 1);
      step;
    end
    enable = 1'b1;
    #1;
    for (int k = 4; k < 8; k++) begin
      chk("stall_post_bit", ser_out, c3[W-1-k]);
      chk("stall_post_valid", ser_valid, 1);
      chk("stall_post_last", ser_last, k == 7);
      step;
    end
    chk("stall_done", ser_valid, 0);
    // reset mid-word with a word held
    in_valid = 1'b1; in_data = 8'hFF; direction = 1'b0;
    step;
    in_data = 8'h00;
    step;
    in_valid = 1'b0;
    repeat (3) step;
    chk("mid_hold_full", in_ready, 0);
    chk("mid_bit", ser_out, 1);
    #2 reset = 1'b0;
    #1;
    chk("arst_out", ser_out, 0);
    chk("arst_valid", ser_valid, 0);
    chk("arst_first", ser_first, 0);
    chk("arst_last", ser_last, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ready", in_ready, 1);
    step;
    reset = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("post_rst_ready", in_ready, 1);
      chk("post_rst_valid", ser_valid, 0);
      chk("post_rst_busy", busy, 0);
      step;
    end
    send_check(8'h96, 1'b0, 8'h96);
    // random traffic against a word-queue reference model
    act = 1'b0; idx = 0;
    for (int c = 0; c < 800; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data = W'($urandom);
      direction = 1'($urandom_range(0, 1));
      enable = ($urandom_range(0, 3) != 0);
      #1;
      chk("rnd_valid", ser_valid, act && enable);
      chk("rnd_ready", in_ready, hold_q.size() == 0);
      chk("rnd_busy", busy, act || hold_q.size() != 0);
      if (act && enable) begin
        chk("rnd_bit", ser_out, cur.dir ? cur.data[idx] : cur.data[W-1-idx]);
        chk("rnd_first", ser_first, idx == 0);
        chk("rnd_last", ser_last, idx == W - 1);
      end
      acc = in_valid && hold_q.size() == 0;
      if (act && enable) begin
        idx++;
        if (idx == W) act = 1'b0;
      end
      if (!act && hold_q.size() != 0) begin
        cur = hold_q.pop_front(); act = 1'b1; idx = 0;
      end else if (!act && acc) begin
        cur = '{in_data, direction}; act = 1'b1; idx = 0; acc = 1'b0;
      end
      if (acc) hold_q.push_back('{in_data, direction});
      step;
    end
    in_valid = 1'b0; enable = 1'b1;
    for (int c = 0; c < 40 && busy; c++) step;
    chk("rnd_drain_busy", busy, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
